// File: rtl/dlx_fetch_stage_if.sv
// dlx_fetch_stage_if: fetch-stage bundle (imem port, redirect, IF/ID).
// master = fetch stage side, slave = memory/decode side.
interface dlx_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus_four;

  modport master (
    output imem_req, imem_addr,
    output if_id_valid, if_id_instr,
    output if_id_pc_plus_four,
    input  imem_gnt, imem_rvalid,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    input  id_stall
  );

  modport slave (
    input  imem_req, imem_addr,
    input  if_id_valid, if_id_instr,
    input  if_id_pc_plus_four,
    output imem_gnt, imem_rvalid,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    output id_stall
  );
endinterface

// File: rtl/dlx_fetch_stage.sv
// dlx_fetch_stage: DLX fetch - PC, single-outstanding imem requests,
// IF/ID register with one-entry skid buffer, redirect squash.
// Ports: clk, rst_n (async, active low), bus (dlx_fetch_stage_if.master).
// DLX_DELAY_SLOT_EN: keep the instruction after a branch (delay slot).
module dlx_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  dlx_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_FULL
  } state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        disc_q, disc_d;
  if_id_t      skid_q, skid_d;
  if_id_t      if_id_q, if_id_d;
  if_id_t      rsp, load_w;
  logic        redir_acc, squash, load;

  assign redir_acc = bus.redirect_valid & if_id_q.vld
                   & ~bus.id_stall;

  assign rsp = '{vld: 1'b1,
                 instr: bus.imem_rdata,
                 pc4: addr_q + 32'd4};

`ifdef DLX_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  assign squash = 1'b0;
`else
  assign squash = redir_acc;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    disc_d  = disc_q;
    skid_d  = skid_q;
    if_id_d = if_id_q;
    load    = 1'b0;
    load_w  = skid_q;
`ifdef DLX_DELAY_SLOT_EN
    pend_d  = pend_q;
    tgt_d   = tgt_q;
`endif
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_gnt) begin
          state_d = S_WAIT;
          addr_d  = {pc_q[31:2], 2'b00};
          pc_d    = pc_q + 32'd4;
          // granted wrong-path fetch: drop its data later
          disc_d  = squash;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          disc_d  = 1'b0;
          state_d = S_REQ;
          if (!(disc_q || squash)) begin
            if (!bus.id_stall) begin
              load   = 1'b1;
              load_w = rsp;
            end else begin
              skid_d  = rsp;
              state_d = S_FULL;
            end
          end
        end else if (squash) begin
          disc_d = 1'b1;
        end
      end
      S_FULL: begin
        if (!bus.id_stall) begin
          state_d    = S_REQ;
          skid_d.vld = 1'b0;
          load       = ~squash;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (squash) pc_d = bus.redirect_pc;

`ifdef DLX_DELAY_SLOT_EN
    // first delivery after the branch is the slot
    if (load && (pend_q || redir_acc)) begin
      pc_d   = pend_q ? tgt_q : bus.redirect_pc;
      pend_d = 1'b0;
    end else if (redir_acc) begin
      pend_d = 1'b1;
      tgt_d  = bus.redirect_pc;
    end
`endif

    if (!bus.id_stall) begin
      if_id_d.vld = 1'b0;
      if (load) if_id_d = load_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      disc_q  <= 1'b0;
      skid_q  <= '0;
      if_id_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      disc_q  <= disc_d;
      skid_q  <= skid_d;
      if_id_q <= if_id_d;
    end
  end

`ifdef DLX_DELAY_SLOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end
`endif

  assign bus.imem_req  = (state_q == S_REQ);
  assign bus.imem_addr = {pc_q[31:2], 2'b00};
  assign bus.if_id_valid        = if_id_q.vld;
  assign bus.if_id_instr        = if_id_q.instr;
  assign bus.if_id_pc_plus_four = if_id_q.pc4;

endmodule
